// File: rtl/rx_lane_descrambler.sv
// Per-lane RX descrambler: COM lock FSM, 16-bit Galois LFSR keystream,
// consecutive-error loss-of-lock and a saturating error counter per lane.
module rx_lane_descrambler #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_LIMIT  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_LANES-1:0]            lane_enable_i,
  input  logic                            scramble_dis_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] sym_i,
  input  logic [NUM_LANES-1:0]            sym_is_k_i,
  input  logic [NUM_LANES-1:0]            sym_err_i,
  input  logic [NUM_LANES-1:0]            sym_valid_i,
  input  logic                            err_cnt_clr_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_o,
  output logic [NUM_LANES-1:0]            data_is_k_o,
  output logic [NUM_LANES-1:0]            data_err_o,
  output logic [NUM_LANES-1:0]            data_valid_o,
  output logic [NUM_LANES-1:0]            lane_locked_o,
  output logic [NUM_LANES*8-1:0]          lane_err_cnt_o
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0]  ERR_LIM  = 4'(ERR_LIMIT);
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_adv, lfsr_walk;
    logic [7:0]            key;
    logic [3:0]            cons_q, cons_d, cons_inc;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sym, data_q, data_d;
    logic                  k_q, err_q, valid_q, valid_d;
    logic                  is_com, is_skp, en, v, k, err;

    assign sym    = sym_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign en     = lane_enable_i[gi];
    assign v      = sym_valid_i[gi];
    assign k      = sym_is_k_i[gi];
    assign err    = sym_err_i[gi];
    assign is_com = k && (sym == 8'hBC);
    assign is_skp = k && (sym == 8'h1C);
    assign cons_inc = cons_q + 4'd1;

    // Eight Galois steps per symbol; key bit b is the MSB before step b.
    always_comb begin
      lfsr_walk = lfsr_q;
      key       = '0;
      for (int b = 0; b < 8; b++) begin
        key[b]    = lfsr_walk[15];
        lfsr_walk = {lfsr_walk[14:0], 1'b0} ^ (lfsr_walk[15] ? 16'h0039 : 16'h0000);
      end
      lfsr_adv = lfsr_walk;
    end

    always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cons_d  = cons_q;
      valid_d = 1'b0;
      data_d  = sym;
      if (!en) begin
        state_d = UNLOCKED;
        lfsr_d  = LFSR_SEED;
        cons_d  = '0;
      end else if (v) begin
        if (state_q == UNLOCKED) begin
          if (is_com && !err) begin
            state_d = LOCKED;
            lfsr_d  = LFSR_SEED;
            cons_d  = '0;
            valid_d = 1'b1;
          end
        end else begin
          valid_d = 1'b1;
          if (is_com && !err) lfsr_d = LFSR_SEED;
          else if (!is_skp)   lfsr_d = lfsr_adv;
          if (!k && !err && !scramble_dis_i) data_d = sym ^ key;
          if (err) begin
            if (cons_inc >= ERR_LIM) begin
              state_d = UNLOCKED;
              cons_d  = '0;
            end else begin
              cons_d = cons_inc;
            end
          end else begin
            cons_d = '0;
          end
        end
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      if (err_cnt_clr_i)                          cnt_d = '0;
      else if (en && v && err && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        state_q <= UNLOCKED;
        lfsr_q  <= LFSR_SEED;
        cons_q  <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
        k_q     <= 1'b0;
        err_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        lfsr_q  <= lfsr_d;
        cons_q  <= cons_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        k_q     <= k;
        err_q   <= err;
        valid_q <= valid_d;
      end
    end

    assign data_o[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign data_is_k_o[gi]                     = k_q;
    assign data_err_o[gi]                      = err_q;
    assign data_valid_o[gi]                    = valid_q;
    assign lane_locked_o[gi]                   = (state_q == LOCKED);
    assign lane_err_cnt_o[gi*8 +: 8]           = cnt_q;
  end

endmodule

// File: tb/tb_rx_lane_descrambler.sv
// Directed bench for rx_lane_descrambler: lock, keystream, SKP, loss of lock,
// saturation, lane enable and mid-stream reset.
module tb_rx_lane_descrambler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  lane_enable_i;
  logic        scramble_dis_i;
  logic [31:0] sym_i;
  logic [3:0]  sym_is_k_i, sym_err_i, sym_valid_i;
  logic        err_cnt_clr_i;
  logic [31:0] data_o;
  logic [3:0]  data_is_k_o, data_err_o, data_valid_o, lane_locked_o;
  logic [31:0] lane_err_cnt_o;

  int checks = 0;
  int errors = 0;

  rx_lane_descrambler #(.NUM_LANES(4), .DATA_WIDTH(8), .ERR_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lane_enable_i(lane_enable_i),
    .scramble_dis_i(scramble_dis_i), .sym_i(sym_i), .sym_is_k_i(sym_is_k_i),
    .sym_err_i(sym_err_i), .sym_valid_i(sym_valid_i), .err_cnt_clr_i(err_cnt_clr_i),
    .data_o(data_o), .data_is_k_o(data_is_k_o), .data_err_o(data_err_o),
    .data_valid_o(data_valid_o), .lane_locked_o(lane_locked_o),
    .lane_err_cnt_o(lane_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lane0(input logic [7:0] s, input logic k, input logic e);
    sym_i       = {24'h0, s};
    sym_is_k_i  = {3'b0, k};
    sym_err_i   = {3'b0, e};
    sym_valid_i = 4'b0001;
    step();
    $display("lane0 sym=%02h k=%0b err=%0b -> data=%02h k=%0b err=%0b v=%0b lock=%0b cnt=%0d",
             s, k, e, data_o[7:0], data_is_k_o[0], data_err_o[0], data_valid_o[0],
             lane_locked_o[0], lane_err_cnt_o[7:0]);
  endtask

  task automatic all4(input logic [31:0] s, input logic [3:0] k, input logic [3:0] e);
    sym_i       = s;
    sym_is_k_i  = k;
    sym_err_i   = e;
    sym_valid_i = 4'hF;
    step();
    $display("all sym=%08h k=%04b err=%04b -> data=%08h v=%04b lock=%04b cnt=%08h",
             s, k, e, data_o, data_valid_o, lane_locked_o, lane_err_cnt_o);
  endtask

  initial begin
    rst_i = 1'b0; lane_enable_i = 4'hF; scramble_dis_i = 1'b0; sym_i = '0;
    sym_is_k_i = '0; sym_err_i = '0; sym_valid_i = '0; err_cnt_clr_i = 1'b0;
    #1;
    step(); step();
    chk("rst_data", data_o, 32'h0);
    chk("rst_valid", 32'(data_valid_o), 32'h0);
    chk("rst_locked", 32'(lane_locked_o), 32'h0);
    chk("rst_cnt", lane_err_cnt_o, 32'h0);
    rst_i = 1'b1;

    // 1: lock and first keystream bytes
    lane0(8'hBC, 1'b1, 1'b0);
    chk("t1_com_data", 32'(data_o[7:0]), 32'hBC);
    chk("t1_com_k", 32'(data_is_k_o[0]), 32'h1);
    chk("t1_com_valid", 32'(data_valid_o[0]), 32'h1);
    chk("t1_com_locked", 32'(lane_locked_o[0]), 32'h1);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t1_d0", 32'(data_o[7:0]), 32'hFF);
    chk("t1_d0_k", 32'(data_is_k_o[0]), 32'h0);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t1_d1", 32'(data_o[7:0]), 32'h17);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t1_d2", 32'(data_o[7:0]), 32'hC0);

    // 2: SKP and an idle cycle do not advance the LFSR
    lane0(8'hBC, 1'b1, 1'b0);
    chk("t2_com", 32'(data_o[7:0]), 32'hBC);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t2_d0", 32'(data_o[7:0]), 32'hFF);
    lane0(8'h1C, 1'b1, 1'b0);
    chk("t2_skp", 32'(data_o[7:0]), 32'h1C);
    chk("t2_skp_k", 32'(data_is_k_o[0]), 32'h1);
    sym_valid_i = 4'b0000;
    step();
    chk("t2_idle_valid", 32'(data_valid_o[0]), 32'h0);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t2_d1", 32'(data_o[7:0]), 32'h17);
    chk("t2_d1_valid", 32'(data_valid_o[0]), 32'h1);

    // 3: consecutive errors
    for (int i = 0; i < 3; i++) begin
      lane0(8'hAA, 1'b0, 1'b1);
      chk("t3_err_data", 32'(data_o[7:0]), 32'hAA);
      chk("t3_err_flag", 32'(data_err_o[0]), 32'h1);
      chk("t3_err_locked", 32'(lane_locked_o[0]), 32'h1);
    end
    lane0(8'h00, 1'b0, 1'b0);
    chk("t3_good_locked", 32'(lane_locked_o[0]), 32'h1);
    chk("t3_cnt3", 32'(lane_err_cnt_o[7:0]), 32'h3);
    for (int i = 0; i < 3; i++) begin
      lane0(8'hAA, 1'b0, 1'b1);
      chk("t3_err2_locked", 32'(lane_locked_o[0]), 32'h1);
    end
    lane0(8'hAA, 1'b0, 1'b1);
    chk("t3_drop_locked", 32'(lane_locked_o[0]), 32'h0);
    chk("t3_drop_valid", 32'(data_valid_o[0]), 32'h1);
    chk("t3_drop_err", 32'(data_err_o[0]), 32'h1);
    chk("t3_cnt7", 32'(lane_err_cnt_o[7:0]), 32'h7);

    // 4: unlocked lane discards until a clean COM
    lane0(8'h55, 1'b0, 1'b0);
    chk("t4_data_valid", 32'(data_valid_o[0]), 32'h0);
    lane0(8'hBC, 1'b1, 1'b1);
    chk("t4_badcom_valid", 32'(data_valid_o[0]), 32'h0);
    chk("t4_badcom_locked", 32'(lane_locked_o[0]), 32'h0);
    lane0(8'hBC, 1'b1, 1'b0);
    chk("t4_com_locked", 32'(lane_locked_o[0]), 32'h1);
    chk("t4_com_valid", 32'(data_valid_o[0]), 32'h1);
    lane0(8'h00, 1'b0, 1'b0);
    chk("t4_d0", 32'(data_o[7:0]), 32'hFF);
    chk("t4_cnt8", 32'(lane_err_cnt_o[7:0]), 32'h8);

    // scramble bypass still advances the LFSR
    scramble_dis_i = 1'b1;
    lane0(8'h00, 1'b0, 1'b0);
    chk("byp_data", 32'(data_o[7:0]), 32'h00);
    scramble_dis_i = 1'b0;
    lane0(8'h00, 1'b0, 1'b0);
    chk("byp_after", 32'(data_o[7:0]), 32'hC0);

    // 5: saturation and clear priority
    for (int i = 0; i < 300; i++) lane0(8'h00, 1'b0, 1'b1);
    chk("t5_sat", 32'(lane_err_cnt_o[7:0]), 32'hFF);
    err_cnt_clr_i = 1'b1;
    lane0(8'h00, 1'b0, 1'b1);
    chk("t5_clr", 32'(lane_err_cnt_o[7:0]), 32'h0);
    err_cnt_clr_i = 1'b0;
    lane0(8'h00, 1'b0, 1'b1);
    chk("t5_inc", 32'(lane_err_cnt_o[7:0]), 32'h1);

    // 6: four lanes, staggered COMs
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    all4(32'h000000BC, 4'b0001, 4'b0000);
    chk("t6_c1_valid", 32'(data_valid_o), 32'h1);
    chk("t6_c1_locked", 32'(lane_locked_o), 32'h1);
    all4(32'h0000BC00, 4'b0010, 4'b0000);
    chk("t6_c2_valid", 32'(data_valid_o), 32'h3);
    chk("t6_c2_data", 32'(data_o[15:0]), 32'hBCFF);
    all4(32'h00BC0000, 4'b0100, 4'b0000);
    chk("t6_c3_valid", 32'(data_valid_o), 32'h7);
    all4(32'hBC000000, 4'b1000, 4'b0000);
    chk("t6_c4_data", data_o, 32'hBCFF17C0);
    chk("t6_c4_locked", 32'(lane_locked_o), 32'hF);
    lane_enable_i = 4'b1011;
    all4(32'h00000000, 4'b0000, 4'b0000);
    chk("t6_c5_valid", 32'(data_valid_o), 32'hB);
    chk("t6_c5_locked", 32'(lane_locked_o), 32'hB);
    chk("t6_c5_l0", 32'(data_o[7:0]), 32'h14);
    chk("t6_c5_l1", 32'(data_o[15:8]), 32'hC0);
    chk("t6_c5_l3", 32'(data_o[31:24]), 32'hFF);
    lane_enable_i = 4'hF;
    all4(32'h00000000, 4'b0000, 4'b0010);
    chk("t6_c6_valid", 32'(data_valid_o), 32'hB);
    chk("t6_c6_l0", 32'(data_o[7:0]), 32'hB2);
    chk("t6_c6_l1", 32'(data_o[15:8]), 32'h00);
    chk("t6_c6_cnt", lane_err_cnt_o, 32'h00000100);
    rst_i = 1'b0;
    all4(32'h00000000, 4'b0000, 4'b0000);
    chk("t6_rst_data", data_o, 32'h0);
    chk("t6_rst_valid", 32'(data_valid_o), 32'h0);
    chk("t6_rst_locked", 32'(lane_locked_o), 32'h0);
    chk("t6_rst_cnt", lane_err_cnt_o, 32'h0);
    rst_i = 1'b1;
    lane0(8'h00, 1'b0, 1'b0);
    chk("t6_relock_needed", 32'(data_valid_o[0]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
